hazard_fwd_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage core. It tracks destination-register information for the instructions in ID/EX, EX/MEM and MEM/WB in its own shadow pipeline. From that it produces registered forward_a/forward_b selects for the EX stage operand muxes, a load-use stall, and branch flush controls. It sits beside the pipeline registers, between decode and the EX stage.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 27 ++
 rtl/hazard_fwd_ctrl_fwd_sel.sv | 24 ++
 rtl/hazard_fwd_ctrl.sv | 92 +++++++++
 tb/tb_hazard_fwd_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// The shadow-stage record mirrors the destination info carried down the pipeline.
package hazard_fwd_ctrl_pkg;

  localparam int REG_AW = 3;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

  localparam shadow_t WRITES_MASK = '{valid: 1'b1, rd: '1, reg_write: 1'b1, mem_read: 1'b0};

  // True when the entry is a live register write to r; mem_read is masked out.
  function automatic logic writes_reg(input shadow_t s, input logic [REG_AW-1:0] r);
    shadow_t want;
    want = '{valid: 1'b1, rd: r, reg_write: 1'b1, mem_read: 1'b0};
    return ((s ^ want) & WRITES_MASK) == '0;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Operand forward select for one EX source: youngest non-load producer first,
// then the MEM/WB producer, else the register file.
module hazard_fwd_ctrl_fwd_sel
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  shadow_t           ex_s,
  input  shadow_t           mem_s,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (used) begin
      if (writes_reg(ex_s, src) && !ex_s.mem_read) begin
        sel = FWD_EXMEM;
      end else if (writes_reg(mem_s, src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: shadow pipeline of destination info, registered
// forward selects, load-use stall, branch flush and saturating event counters.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_stall,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output shadow_t           dbg_ex_s,
  output shadow_t           dbg_mem_s,
  output shadow_t           dbg_wb_s
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  shadow_t    ex_s, mem_s, wb_s, id_s;
  logic       load_use;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  assign id_s = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  assign flush    = ex_branch_taken && ex_s.valid;
  assign load_use = ex_s.mem_read && id_valid &&
                    ((id_rs_used && writes_reg(ex_s, id_rs)) ||
                     (id_rt_used && writes_reg(ex_s, id_rt)));
  assign stall    = load_use && !flush && !mem_stall;

  hazard_fwd_ctrl_fwd_sel u_fwd_a (
    .src   (id_rs),
    .used  (id_valid && id_rs_used),
    .ex_s  (ex_s),
    .mem_s (mem_s),
    .sel   (fwd_a_nxt)
  );

  hazard_fwd_ctrl_fwd_sel u_fwd_b (
    .src   (id_rt),
    .used  (id_valid && id_rt_used),
    .ex_s  (ex_s),
    .mem_s (mem_s),
    .sel   (fwd_b_nxt)
  );

  // mem_stall freezes everything; flush and stall both inject a bubble into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_s        <= '0;
      mem_s       <= '0;
      wb_s        <= '0;
      forward_a   <= FWD_RF;
      forward_b   <= FWD_RF;
      stall_count <= '0;
      flush_count <= '0;
    end else if (!mem_stall) begin
      mem_s <= ex_s;
      wb_s  <= mem_s;
      if (flush || stall) begin
        ex_s      <= '0;
        forward_a <= FWD_RF;
        forward_b <= FWD_RF;
        if (flush && flush_count != '1) flush_count <= flush_count + CNT_ONE;
        if (!flush && stall_count != '1) stall_count <= stall_count + CNT_ONE;
      end else begin
        ex_s      <= id_s;
        forward_a <= fwd_a_nxt;
        forward_b <= fwd_b_nxt;
      end
    end
  end

  assign dbg_ex_s  = ex_s;
  assign dbg_mem_s = mem_s;
  assign dbg_wb_s  = wb_s;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed hazard scenarios then random traffic,
// compared against an instruction-history reference model.
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              ex_branch_taken, mem_stall;
  logic [1:0]        forward_a, forward_b;
  logic              stall, flush;
  logic [CNT_W-1:0]  stall_count, flush_count;
  shadow_t           dbg_ex_s, dbg_mem_s, dbg_wb_s;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall(stall), .flush(flush),
    .stall_count(stall_count), .flush_count(flush_count),
    .dbg_ex_s(dbg_ex_s), .dbg_mem_s(dbg_mem_s), .dbg_wb_s(dbg_wb_s)
  );

  // Reference: hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB.
  typedef struct { bit valid; int rd; bit rw; bit ld; } ins_t;
  ins_t hist[$];
  int   exp_fa, exp_fb, exp_sc, exp_fc;
  int   n_checks = 0, n_errors = 0;
  logic last_stall, last_flush;
  int   max_cnt = (1 << CNT_W) - 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ins_t b;
    b = '{valid: 0, rd: 0, rw: 0, ld: 0};
    hist.delete();
    repeat (3) hist.push_back(b);
    exp_fa = 0; exp_fb = 0; exp_sc = 0; exp_fc = 0;
  endtask

  function automatic bit writes(ins_t e, int r);
    return e.valid && e.rw && e.rd == r;
  endfunction

  // Search producers from youngest to oldest; a load still in EX cannot forward.
  function automatic int fwd_of(bit used, int src);
    if (!used) return 0;
    for (int d = 0; d < 2; d++) begin
      if (writes(hist[d], src) && !(d == 0 && hist[0].ld)) return (d == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  task automatic step(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                      input int rd, input bit rw, input bit ld, input bit br, input bit ms);
    bit   lu, ef, es;
    int   nfa, nfb;
    ins_t n;
    @(negedge clk);
    id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
    id_rs_used = rsu; id_rt_used = rtu; id_rd = REG_AW'(rd);
    id_reg_write = rw; id_mem_read = ld; ex_branch_taken = br; mem_stall = ms;
    #1;
    lu = hist[0].valid && hist[0].ld && hist[0].rw && v &&
         ((rsu && rs == hist[0].rd) || (rtu && rt == hist[0].rd));
    ef = br && hist[0].valid;
    es = lu && !ef && !ms;
    check("flush", flush, ef);
    check("stall", stall, es);
    last_stall = stall;
    last_flush = flush;
    @(posedge clk);
    if (!ms) begin
      if (ef || es) begin
        n = '{valid: 0, rd: 0, rw: 0, ld: 0};
        exp_fa = 0; exp_fb = 0;
        if (ef) exp_fc = (exp_fc < max_cnt) ? exp_fc + 1 : exp_fc;
        else    exp_sc = (exp_sc < max_cnt) ? exp_sc + 1 : exp_sc;
      end else begin
        nfa = fwd_of(v && rsu, rs);
        nfb = fwd_of(v && rtu, rt);
        n = '{valid: v, rd: rd, rw: rw, ld: ld};
        exp_fa = nfa; exp_fb = nfb;
      end
      hist.push_front(n);
      void'(hist.pop_back());
    end
    #1;
    check("forward_a", forward_a, exp_fa);
    check("forward_b", forward_b, exp_fb);
    check("stall_count", stall_count, exp_sc);
    check("flush_count", flush_count, exp_fc);
    check("ex_valid", dbg_ex_s.valid, hist[0].valid);
  endtask

  task automatic alu(input int rd, input int rs, input int rt, input bit br = 0, input bit ms = 0);
    step(1, rs, rt, 1, 1, rd, 1, 0, br, ms);
  endtask

  task automatic load(input int rd, input int rs);
    step(1, rs, 0, 1, 0, rd, 1, 1, 0, 0);
  endtask

  logic [1:0]       fa_hold;
  logic [CNT_W-1:0] sc_hold, fc_hold;

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0; id_rd = '0;
    id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0; mem_stall = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_fa", forward_a, 0);
    check("rst_fb", forward_b, 0);
    check("rst_sc", stall_count, 0);
    check("rst_fc", flush_count, 0);
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back ALU dependence
    alu(1, 5, 6);
    alu(7, 1, 2);
    check("b2b_fa", forward_a, 2'b10);
    check("b2b_nostall", last_stall, 0);

    // distance-2 dependence on rt
    alu(2, 5, 6);
    alu(5, 6, 6);
    alu(0, 6, 2);
    check("d2_fb", forward_b, 2'b01);

    // double producer: youngest wins
    alu(3, 5, 6);
    alu(3, 5, 6);
    alu(6, 3, 5);
    check("dbl_fa", forward_a, 2'b10);

    // load-use
    check("lu_sc0", stall_count, 0);
    load(4, 5);
    alu(7, 4, 5);
    check("lu_stall", last_stall, 1);
    check("lu_sc1", stall_count, 1);
    alu(7, 4, 5);
    check("lu_stall_once", last_stall, 0);
    check("lu_fa", forward_a, 2'b01);
    check("lu_sc_hold", stall_count, 1);

    // flush coincident with load-use
    load(4, 5);
    alu(7, 4, 5, 1);
    check("fl_flush", last_flush, 1);
    check("fl_stall", last_stall, 0);
    check("fl_fc", flush_count, 1);
    check("fl_fa", forward_a, 0);
    check("fl_fb", forward_b, 0);
    check("fl_bubble", dbg_ex_s.valid, 0);

    // freeze with a pending forward
    alu(6, 4, 5);
    fa_hold = forward_a;
    sc_hold = stall_count;
    fc_hold = flush_count;
    check("frz_pending", fa_hold, 2'b01);
    repeat (3) begin
      alu(1, 6, 5, 0, 1);
      check("frz_fa", forward_a, fa_hold);
      check("frz_sc", stall_count, sc_hold);
      check("frz_fc", flush_count, fc_hold);
    end
    alu(1, 6, 5);
    check("frz_resume_fa", forward_a, 2'b10);

    // asynchronous reset mid-sequence
    load(4, 5);
    alu(7, 4, 5);
    alu(7, 4, 5);
    check("pre_rst_sc", stall_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fa", forward_a, 0);
    check("arst_fb", forward_b, 0);
    check("arst_sc", stall_count, 0);
    check("arst_fc", flush_count, 0);
    check("arst_stall", stall, 0);
    check("arst_flush", flush, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic over a small register window to provoke hazards and saturation
    repeat (3000) begin
      bit ld_r;
      ld_r = ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3),
           ld_r || ($urandom_range(0, 3) != 0), ld_r,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
